// File: rtl/movavg_inv.sv
// movavg_inv -- inverse of the TAPS-tap moving-sum filter.
//
// Takes the forward filter's output stream y and rebuilds the original
// samples x bit-exactly with the recurrence
//     x[n] = y[n] - y[n-1] + x[n-TAPS]   (all arithmetic modulo 2^W)
// which follows from y[n] - y[n-1] = x[n] - x[n-TAPS].
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   y_in       filtered sample from the forward filter
//   in_valid   y_in is valid this cycle
//   in_ready   block can take a sample this cycle
//   x_out      reconstructed sample (registered)
//   out_valid  x_out is valid
//   out_ready  downstream takes x_out this cycle
//   count      number of samples handed downstream since reset (wraps)
module movavg_inv #(
  parameter int W    = 64,
  parameter int TAPS = 4,
  parameter int CW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  y_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  x_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  // Previous accepted input and history of decoded samples.
  // xh_reg[k] holds x[n-k] relative to the next sample to be decoded.
  logic [W-1:0]  y_prev_reg;
  logic [W-1:0]  xh_reg [1:TAPS];

  logic [W-1:0]  x_out_reg;
  logic          out_valid_reg;
  logic [CW-1:0] count_reg;

  logic          accept;
  logic          xfer;
  logic [W-1:0]  x_next;

  // Single-entry output stage: room whenever it is empty or being drained
  // in the same cycle, so back-to-back samples flow at one per clock.
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_reg && out_ready;

  // Modular subtraction/addition wraps naturally at W bits.
  assign x_next   = y_in - y_prev_reg + xh_reg[TAPS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_prev_reg <= '0;
      for (int k = 1; k <= TAPS; k++) begin
        xh_reg[k] <= '0;
      end
    end else if (accept) begin
      // History advances only on accepted samples; idle and stalled
      // cycles leave it untouched so bubbles cannot corrupt the decode.
      y_prev_reg <= y_in;
      for (int k = TAPS; k >= 2; k--) begin
        xh_reg[k] <= xh_reg[k-1];
      end
      xh_reg[1] <= x_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_out_reg     <= '0;
      out_valid_reg <= 1'b0;
      count_reg     <= '0;
    end else begin
      if (accept) begin
        // A new sample replaces the output even when the old one is
        // leaving this same cycle, keeping valid high with no gap.
        x_out_reg     <= x_next;
        out_valid_reg <= 1'b1;
      end else if (xfer) begin
        out_valid_reg <= 1'b0;
      end
      if (xfer) begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign x_out     = x_out_reg;
  assign out_valid = out_valid_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_movavg_inv.sv
// Testbench for movavg_inv: scoreboard-checked decode of directed and
// randomized streams, with backpressure, bubbles and mid-stream reset.
module tb_movavg_inv;

  localparam int W    = 64;
  localparam int TAPS = 4;
  localparam int CW   = 32;

  logic          clk;
  logic          reset;
  logic [W-1:0]  y_in;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x_out;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;

  movavg_inv #(.W(W), .TAPS(TAPS), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Scoreboard and received-output log.
  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_log [$];
  logic [W-1:0] exp_log [$];

  // Reference model: the last TAPS-1 original samples, newest first.
  // y[n] is the plain sum of x[n] and these; decoding subtracts them.
  logic [W-1:0] hist [TAPS-1];

  int n_acc    = 0;
  int bp_at    = 0;
  int stall_cnt = 0;
  bit rand_ready = 0;

  logic [W-1:0] basic_y [6] = '{64'd1, 64'd3, 64'd6, 64'd10, 64'd14, 64'd18};

  function automatic logic [W-1:0] hist_sum();
    logic [W-1:0] s = '0;
    for (int i = 0; i < TAPS-1; i++) s = s + hist[i];
    return s;
  endfunction

  function automatic void hist_push(input logic [W-1:0] x);
    for (int i = TAPS-2; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endfunction

  // Downstream ready generator: the only writer of out_ready.
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt = stall_cnt - 1;
    end else if (rand_ready) begin
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: compares every output transfer against the scoreboard.
  int           n_xfer = 0;
  bit           have_held = 0;
  logic [W-1:0] held;
  always @(negedge clk) begin
    if (!reset) begin
      n_xfer    = 0;
      have_held = 0;
      tests = tests + 1;
      if (out_valid !== 1'b0 || x_out !== '0 || count !== '0 || in_ready !== 1'b1) begin
        fails = fails + 1;
        $display("FAIL reset_state: out_valid=%b x_out=%h count=%0d in_ready=%b, required 0/0/0/1",
                 out_valid, x_out, count, in_ready);
      end
    end else if (out_valid && out_ready) begin
      tests = tests + 1;
      if (exp_q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_output: x_out=%h with empty scoreboard", x_out);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (x_out !== e) begin
          fails = fails + 1;
          $display("FAIL x_out[%0d]: got %h, required %h", n_xfer, x_out, e);
        end
      end
      tests = tests + 1;
      if (count !== CW'(n_xfer)) begin
        fails = fails + 1;
        $display("FAIL count_at_xfer: got %0d, required %0d", count, n_xfer);
      end
      got_log.push_back(x_out);
      n_xfer    = n_xfer + 1;
      have_held = 0;
    end else if (out_valid) begin
      tests = tests + 1;
      if (in_ready !== 1'b0) begin
        fails = fails + 1;
        $display("FAIL stall_in_ready: got %b, required 0", in_ready);
      end
      if (have_held) begin
        tests = tests + 1;
        if (x_out !== held) begin
          fails = fails + 1;
          $display("FAIL stall_hold: got %h, required %h", x_out, held);
        end
      end
      held      = x_out;
      have_held = 1;
    end else begin
      have_held = 0;
    end
  end

  // Drive one sample and wait (bounded) until it is accepted.
  task automatic send(input logic [W-1:0] y, input logic [W-1:0] x_exp);
    int waited = 0;
    in_valid = 1'b1;
    y_in     = y;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL accept_timeout: in_ready=%b, required 1 within 100 cycles", in_ready);
    end else begin
      exp_q.push_back(x_exp);
      hist_push(x_exp);
      n_acc = n_acc + 1;
      if (n_acc == bp_at) stall_cnt = 3;
    end
    @(posedge clk);
    #1;
  endtask

  // Encoded sample: decode expectation is y minus the earlier taps.
  task automatic send_y(input logic [W-1:0] y);
    send(y, y - hist_sum());
  endtask

  // Raw sample: run it through the forward filter model first.
  task automatic send_x(input logic [W-1:0] x);
    send(x + hist_sum(), x);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    y_in     = {$urandom(), $urandom()};
    repeat (n) begin
      @(posedge clk);
      #1;
      y_in = {$urandom(), $urandom()};
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b0;
    exp_q.delete();
    got_log.delete();
    for (int i = 0; i < TAPS-1; i++) hist[i] = '0;
    n_acc = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Wait for the scoreboard to empty, then check the final count.
  task automatic drain(input int exp_count);
    int waited = 0;
    in_valid = 1'b0;
    while (exp_q.size() > 0 && waited < 2000) begin
      waited++;
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #2;
    tests = tests + 1;
    if (count !== CW'(exp_count)) begin
      fails = fails + 1;
      $display("FAIL final_count: got %0d, required %0d", count, exp_count);
    end
  endtask

  task automatic check_log(input string name);
    tests = tests + 1;
    if (got_log.size() != exp_log.size()) begin
      fails = fails + 1;
      $display("FAIL %s_len: got %0d outputs, required %0d", name, got_log.size(), exp_log.size());
    end else begin
      for (int i = 0; i < exp_log.size(); i++) begin
        if (got_log[i] !== exp_log[i]) begin
          fails = fails + 1;
          $display("FAIL %s[%0d]: got %h, required %h", name, i, got_log[i], exp_log[i]);
          break;
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    y_in     = '0;
    for (int i = 0; i < TAPS-1; i++) hist[i] = '0;

    // Basic decode.
    do_reset();
    foreach (basic_y[i]) send_y(basic_y[i]);
    drain(6);
    exp_log = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6};
    check_log("basic");
    $display("[TB] basic decode done");

    // Backpressure: downstream stalls 3 cycles while 2 is presented.
    do_reset();
    bp_at = 2;
    foreach (basic_y[i]) send_y(basic_y[i]);
    drain(6);
    bp_at = 0;
    check_log("backpressure");
    $display("[TB] backpressure done");

    // Bubbles with garbage on idle cycles.
    do_reset();
    foreach (basic_y[i]) begin
      send_y(basic_y[i]);
      idle(1 + (i % 2));
    end
    drain(6);
    check_log("bubbles");
    $display("[TB] bubbles done");

    // Wrap-around.
    do_reset();
    send_y(64'hFFFF_FFFF_FFFF_FFFF);
    send_y(64'd0);
    drain(2);
    exp_log = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    check_log("wrap");
    $display("[TB] wrap done");

    // Mid-stream reset.
    do_reset();
    send_y(64'd1);
    send_y(64'd3);
    send_y(64'd6);
    do_reset();
    send_y(64'd1);
    send_y(64'd3);
    send_y(64'd6);
    send_y(64'd10);
    drain(4);
    exp_log = '{64'd1, 64'd2, 64'd3, 64'd4};
    check_log("midreset");
    $display("[TB] mid-stream reset done");

    // Loop-back of random samples through the forward filter model.
    do_reset();
    rand_ready = 1;
    for (int i = 0; i < 1024; i++) begin
      send_x({$urandom(), $urandom()});
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    drain(1024);
    rand_ready = 0;
    $display("[TB] loop-back done, %0d outputs", got_log.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/movavg_inv.md
# movavg_inv

Inverse of the 4-tap moving-sum filter `movavg` (dout = x[n]+x[n-1]+x[n-2]+x[n-3], modulo 2^64, all taps zero after reset). It accepts the filter's output stream and reconstructs the original input samples bit-exactly. It sits downstream of `movavg` in the glsim chain, so a loop-back bench can compare decoded samples against the stimulus. A valid/ready handshake lets it tolerate stalls on both sides.

## Interface
- `W`, 64: sample width; all arithmetic is modulo 2^W.
- `TAPS`, 4: number of taps in the forward filter being inverted (≥2).
- `CW`, 32: width of the sample counter.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; one clock domain only.
- `y_in`  in  W  filtered sample (forward filter output).
- `in_valid`  in  1  `y_in` valid this cycle.
- `in_ready`  out  1  block can accept a sample this cycle.
- `x_out`  out  W  reconstructed sample.
- `out_valid`  out  1  `x_out` valid.
- `out_ready`  in  1  downstream accepts `x_out` this cycle.
- `count`  out  CW  number of samples emitted since reset.

## Operation
- Recurrence: x[n] = y[n] − y[n−1] + x[n−TAPS], computed modulo 2^W with wrap and no saturation.
- State:
  - `y_prev` (W bits).
  - x history shift register `xh[1..TAPS]`, where `xh[k]` = x[n−k].
  - Output register plus `out_valid`.
  - `count`.
- Input accept: when `in_valid && in_ready`:
  - x = `y_in` − `y_prev` + `xh[TAPS]`.
  - x loads into the output register, and `out_valid` is set.
  - `y_prev` ← `y_in`.
  - History shifts: `xh[k]` ← `xh[k−1]`, and `xh[1]` ← x.
- Otherwise all history and `y_prev` hold. History advances only on accepted inputs, never on idle or stall cycles.
- `in_ready` = !`out_valid` || `out_ready` (combinational). This gives a single-entry pipeline with full throughput when not stalled.
- Output handshake:
  - Transfer occurs when `out_valid && out_ready`.
  - If no new input is accepted in the same cycle, `out_valid` clears next cycle.
  - On a simultaneous output transfer and input accept, `out_valid` stays 1 and `x_out` takes the new value.
- While `out_valid && !out_ready`, `x_out` is held stable and `in_ready` = 0. A stalled `y_in` is not consumed.
- `count` increments by 1 on each output transfer and wraps at 2^CW.
- Reset state: all history and `y_prev` are zero, which matches the forward filter's zeroed taps.

## Timing
- Reset (async assert, value held while `reset`=0):
  - `out_valid`=0, `x_out`=0, `count`=0, `in_ready`=1.
  - `y_prev`=0 and `xh[*]`=0.
- Deassertion is expected to be synchronous to `clk` (bench releases away from the edge). The first accept is possible on the first rising edge after release.
- Latency: a sample accepted at edge k appears on `x_out` with `out_valid`=1 immediately after edge k, i.e. 1 cycle.
- DII = 1 when `out_ready` is held high.
- Reset asserted mid-stream:
  - Any pending output and all history are discarded immediately.
  - The decoded stream restarts as if at time 0.
  - The forward filter must be reset together with this block, or the decode is invalid.
- `in_valid` may drop without a transfer, and `y_in` may change when `in_valid`=0. The block samples only on accepts.
- Wrap-around: differences and sums wrap modulo 2^W. No overflow flag is produced.

## Test plan
- Basic decode:
  - Stimulus: reset, then `out_ready`=1 and `y_in` = 1, 3, 6, 10, 14, 18 on consecutive cycles.
  - Required: `x_out` = 1, 2, 3, 4, 5, 6, each one cycle after its input; `count`=6.
- Wrap:
  - Stimulus: `y_in` = FFFF_FFFF_FFFF_FFFF, then 0.
  - Required: `x_out` = FFFF_FFFF_FFFF_FFFF, then 1.
- Backpressure:
  - Stimulus: same stream as basic decode, with `out_ready` low for 3 cycles after the 2nd output.
  - Required: `x_out` holds 2, `in_ready`=0 during the stall, no sample is lost, and the sequence resumes 3, 4, 5, 6.
- Bubbles:
  - Stimulus: `in_valid` toggling 1/0 with garbage `y_in` on idle cycles.
  - Required: output identical to the unbubbled run; history is unaffected by the idle cycles.
- Mid-stream reset:
  - Stimulus: pulse `reset` low after 3 samples, then restart the stream 1, 3, 6, 10.
  - Required: `out_valid`=0 and `count`=0 during reset, then output 1, 2, 3, 4.
- Loop-back:
  - Stimulus: 1024 `$random` 64-bit x fed through `movavg` into this block, `out_ready` randomized.
  - Required: every `x_out` equals the corresponding x, in order, and `count`=1024.
